ring_johnson_counter: RTL and testbench
=======================================

RING_JOHNSON_COUNTER -- requirements
Module: ring_johnson_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 SHALL provide ports, one per line:
 clk  input  1  single clock; all state updates on rising edge.
 rst  input  1  asynchronous, active-high reset.
 en  input  1  step enable.
 mode  input  1  0 = ring (one-hot rotate), 1 = Johnson (twisted ring).
 dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
 load  input  1  synchronous parallel load strobe.
 load_val  input  WIDTH  value written on load.
 q  output  WIDTH  counter state, driven directly from register.
 wrap  output  1  registered one-cycle pulse, sequence returned to seed.
 err  output  1  combinational flag, q is not a legal code for the active mode.

Function
REQ-003 SHALL hold an internal registered mode_r; seed = {WIDTH-1 zeros, 1} when mode_r=0, all zeros when mode_r=1.
REQ-004 SHALL apply per-cycle priority: load > mode change (mode != mode_r) > en > hold.
REQ-005 On load, SHALL set q = load_val as given, legal or not; mode_r unchanged; wrap=0 next cycle.
REQ-006 On mode change without load, SHALL set mode_r = mode and q = seed of the new mode next cycle; wrap=0.
REQ-007 Ring step, dir=0: q <= {q[WIDTH-2:0], q[WIDTH-1]}; dir=1: q <= {q[0], q[WIDTH-1:1]}.
REQ-008 Johnson step, dir=0: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; dir=1: q <= {~q[0], q[WIDTH-1:1]}.
REQ-009 With en=0 and no load or mode change, SHALL hold q; dir changes take effect on the next step with no re-seed.
REQ-010 Legality: ring SHALL require exactly one bit set; Johnson SHALL require q or ~q to equal 2^k-1 for some k in 0..WIDTH.
REQ-011 err SHALL equal NOT legal(q, mode_r), zero latency.
REQ-012 wrap SHALL assert for exactly one cycle, in the cycle after an en step whose next q equals seed; never on load, reset or mode re-seed.
REQ-013 Period from seed SHALL be WIDTH steps in ring mode and 2*WIDTH steps in Johnson mode, either direction.
REQ-014 Outputs SHALL be glitch-free registered values except err.

Reset
REQ-015 rst=1 SHALL immediately, independent of clk, force q = {WIDTH-1 zeros, 1}, mode_r = 0, wrap = 0.
REQ-016 Reset asserted mid-sequence SHALL discard state; first step after release SHALL proceed from the ring seed. If mode=1 at release, the mode-change rule applies on the first edge.

Configuration
REQ-017 Macro RING_SELF_CORRECT_EN: when defined, an en step taken while err=1 SHALL load seed instead of shifting, with wrap=0. When undefined, an illegal q SHALL shift per REQ-007/008 and err SHALL stay high.

Verification
REQ-018 WIDTH=4, reset, mode=0, dir=0, en=1 for 4 cycles -> q = 0010, 0100, 1000, 0001; wrap high only the cycle q returns to 0001.
REQ-019 WIDTH=4, mode=1, dir=0, en=1 -> re-seed to 0000, then 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap once after the 8th step; err=0 throughout.
REQ-020 WIDTH=4, ring, dir=1 from 0001 -> 1000, 0100, 0010, 0001; Johnson dir=1 from 0000 -> 1000, 1100, 1110.
REQ-021 Ring, load=1 load_val=0101 -> q=0101, err=1; next en step gives 0001 with macro, 1010 without (err stays 1).
REQ-022 Load and mode change in the same cycle -> load wins, q=load_val; following cycle re-seeds to the new mode's seed.
REQ-023 rst pulsed asynchronously between edges at q=0100 -> q=0001 before the next edge, wrap=0, err=0.

Source files
------------

// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter: ring (one-hot rotate) / Johnson (twisted ring) counter
// with direction control, parallel load, a wrap pulse and an illegal-code flag.
// Optional build macro RING_SELF_CORRECT_EN: when defined, a step taken from an
// illegal code reloads the seed instead of shifting.
module ring_johnson_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] q_inv;
    logic             ring_ok, john_ok;

    // Seed of the mode currently latched (ring: LSB one-hot, Johnson: zeros)
    assign seed = mode_q ? '0 : ONE;

    // One step of the active mode; Johnson feeds back the inverted end bit
    always_comb begin
        shift = q_q;
        if (!dir) begin
            shift = {q_q[WIDTH-2:0], (mode_q ? ~q_q[WIDTH-1] : q_q[WIDTH-1])};
        end else begin
            shift = {(mode_q ? ~q_q[0] : q_q[0]), q_q[WIDTH-1:1]};
        end
    end

    // Legal codes: ring is one-hot; Johnson is a thermometer code or its inverse
    always_comb begin
        q_inv   = ~q_q;
        ring_ok = (q_q != '0) && ((q_q & (q_q - ONE)) == '0);
        john_ok = ((q_q & (q_q + ONE)) == '0) || ((q_inv & (q_inv + ONE)) == '0);
    end

    assign err  = mode_q ? ~john_ok : ~ring_ok;
    assign q    = q_q;
    assign wrap = wrap_q;

    // Next state with priority load > mode change > step > hold
    always_comb begin
        q_d    = q_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (mode != mode_q) begin
            mode_d = mode;
            q_d    = mode ? '0 : ONE;
        end else if (en) begin
`ifdef RING_SELF_CORRECT_EN
            if (err) begin
                q_d = seed;
            end else begin
                q_d    = shift;
                wrap_d = (shift == seed);
            end
`else
            q_d    = shift;
            wrap_d = (shift == seed);
`endif
        end
    end

    // State registers; reset forces the ring seed immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= ONE;
            mode_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Self-checking bench for ring_johnson_counter (WIDTH=4): directed literal
// sequences plus randomized traffic against an arithmetic reference model.
module tb_ring_johnson_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         wrap, err;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_on = 1'b0;

    ring_johnson_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .q(q), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (integer arithmetic) ----------------
    function automatic int m_seed(input bit jm);
        return jm ? 0 : 1;
    endfunction

    function automatic int m_step(input int n, input bit jm, input bit d);
        int msb = n / 8;
        int lsb = n % 2;
        if (!d) return (n * 2) % 16 + (jm ? 1 - msb : msb);
        else    return n / 2 + 8 * (jm ? 1 - lsb : lsb);
    endfunction

    function automatic bit m_legal(input int n, input bit jm);
        int bits = 0, trans = 0;
        for (int i = 0; i < W; i++) bits += (n >> i) & 1;
        for (int i = 0; i < W - 1; i++) trans += ((n >> i) & 1) != ((n >> (i + 1)) & 1);
        return jm ? (trans <= 1) : (bits == 1);
    endfunction

    int m_q = 1;
    bit m_mode = 1'b0;
    bit m_wrap = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= 1;
            m_mode <= 1'b0;
            m_wrap <= 1'b0;
        end else if (load) begin
            m_q    <= int'(load_val);
            m_wrap <= 1'b0;
        end else if (mode != m_mode) begin
            m_mode <= mode;
            m_q    <= m_seed(mode);
            m_wrap <= 1'b0;
        end else if (en) begin
`ifdef RING_SELF_CORRECT_EN
            if (!m_legal(m_q, m_mode)) begin
                m_q    <= m_seed(m_mode);
                m_wrap <= 1'b0;
            end else begin
                m_q    <= m_step(m_q, m_mode, dir);
                m_wrap <= m_step(m_q, m_mode, dir) == m_seed(m_mode);
            end
`else
            m_q    <= m_step(m_q, m_mode, dir);
            m_wrap <= m_step(m_q, m_mode, dir) == m_seed(m_mode);
`endif
        end else begin
            m_wrap <= 1'b0;
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_q", int'(q), m_q);
            chk("model_wrap", int'(wrap), int'(m_wrap));
            chk("model_err", int'(err), int'(!m_legal(m_q, m_mode)));
        end
    end

    task automatic step_chk(input string name, input int eq, input int ew, input int ee);
        @(negedge clk);
        chk({name, "_q"}, int'(q), eq);
        chk({name, "_wrap"}, int'(wrap), ew);
        chk({name, "_err"}, int'(err), ee);
    endtask

    initial begin
        int ring_fwd[4]  = '{2, 4, 8, 1};
        int john_fwd[9]  = '{0, 1, 3, 7, 15, 14, 12, 8, 0};
        int john_bwd[3]  = '{8, 12, 14};
        int ring_bwd[5]  = '{1, 8, 4, 2, 1};

        #1 rst = 1'b1;
        @(negedge clk);
        cmp_on = 1'b1;
        chk("reset_q", int'(q), 1);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        // ring forward
        en = 1'b1; mode = 1'b0; dir = 1'b0;
        foreach (ring_fwd[i]) step_chk("ring_fwd", ring_fwd[i], i == 3, 0);
        en = 1'b0;
        step_chk("ring_hold", 1, 0, 0);

        // Johnson forward: re-seed then eight steps, wrap on the last
        mode = 1'b1; en = 1'b1;
        foreach (john_fwd[i]) step_chk("john_fwd", john_fwd[i], i == 8, 0);

        // Johnson backward from 0000
        dir = 1'b1;
        foreach (john_bwd[i]) step_chk("john_bwd", john_bwd[i], 0, 0);

        // back to ring (re-seed, no wrap), then backward period
        mode = 1'b0;
        foreach (ring_bwd[i]) step_chk("ring_bwd", ring_bwd[i], i == 4, 0);

        // illegal load in ring mode
        en = 1'b0; load = 1'b1; load_val = 4'b0101;
        step_chk("load_bad", 5, 0, 1);
        load = 1'b0; en = 1'b1; dir = 1'b0;
`ifdef RING_SELF_CORRECT_EN
        step_chk("bad_step", 1, 0, 0);
`else
        step_chk("bad_step", 10, 0, 1);
`endif

        // load and mode change together: load wins, re-seed follows
        en = 1'b0; load = 1'b1; load_val = 4'b0110; mode = 1'b1;
        step_chk("load_vs_mode", 6, 0, 1);
        load = 1'b0;
        step_chk("reseed_after_load", 0, 0, 0);

        // async reset between edges at q=0100
        mode = 1'b0;
        step_chk("ring_reseed", 1, 0, 0);
        en = 1'b1;
        step_chk("ring_s1", 2, 0, 0);
        step_chk("ring_s2", 4, 0, 0);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", int'(q), 1);
        chk("async_rst_wrap", int'(wrap), 0);
        chk("async_rst_err", int'(err), 0);
        #1 rst = 1'b0;

        // randomized traffic, checked by the compare process
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            en       = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst = 1'b0; load = 1'b0; en = 1'b0;
        @(negedge clk);
        cmp_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
